// File: rtl/fxp_conv_pkg.sv
// Shared definitions for the fixed-point to scaled-integer conversion chain.
//   state_t       : converter FSM states (IDLE, MUL, RND, OUT)
//   RND_TRUNC     : rounding mode, truncate toward zero
//   RND_HALF_AWAY : rounding mode, round half away from zero
//   sat_limit()   : magnitude limit of a signed OUT_W-bit result for a given sign
package fxp_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RND  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int RND_TRUNC     = 0;
  localparam int RND_HALF_AWAY = 1;

  // Width used for magnitude/limit comparisons; holds any OUT_W up to 63.
  localparam int LIM_W = 64;

  // Largest representable magnitude: 2^(out_w-1)-1 when positive,
  // 2^(out_w-1) when negative (the most-negative code).
  function automatic logic [LIM_W-1:0] sat_limit(input int out_w, input logic neg);
    logic [LIM_W-1:0] one;
    one = {{(LIM_W-1){1'b0}}, 1'b1};
    if (neg) return one << (out_w - 1);
    else     return (one << (out_w - 1)) - one;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock and asynchronous active-high reset
//   start    : load operands a, b and clear the accumulator
//   a        : multiplicand (A_W bits, unsigned)
//   b        : multiplier (B_W bits, unsigned)
//   done     : high during the cycle that folds in the last multiplier bit;
//              prod is final on the following cycle
//   prod     : accumulated product (A_W+B_W bits, cannot overflow)
module shift_add_mul #(
  parameter int A_W = 11,
  parameter int B_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] prod
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic [P_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign done = busy && (cnt == CNT_W'(B_W - 1));
  assign prod = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (b_q[cnt]) acc <= acc + (P_W'(a_q) << cnt);
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fixed_to_scaled_int.sv
// Converts a signed fixed-point word (value = in_data / 2^FRAC_W) into the
// signed integer value*SCALE, with selectable rounding and saturation to OUT_W.
// One word in flight; result appears SCALE_W+1 cycles after acceptance.
//   clk, rst  : clock and asynchronous active-high reset
//   in_valid  : input word present
//   in_ready  : converter idle, word will be taken
//   in_data   : IN_W-bit two's-complement fixed-point input
//   out_valid : result present, held until out_ready
//   out_ready : downstream accepts result
//   out_data  : OUT_W-bit two's-complement scaled integer
//   out_sat   : result was clipped (qualified by out_valid)
module fixed_to_scaled_int
  import fxp_conv_pkg::*;
#(
  parameter int IN_W       = 10,
  parameter int FRAC_W     = 8,
  parameter int SCALE      = 1000,
  parameter int OUT_W      = 32,
  parameter int ROUND_MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic            out_sat
);

  localparam int SCALE_W = $clog2(SCALE + 1);
  localparam int MAG_W   = IN_W + 1;
  localparam int AW      = MAG_W + SCALE_W;
  localparam int HSH     = (FRAC_W > 0) ? FRAC_W - 1 : 0;
  localparam logic [AW:0] HALF =
    (ROUND_MODE == RND_HALF_AWAY && FRAC_W > 0) ? ({{AW{1'b0}}, 1'b1} << HSH) : '0;

  state_t state, state_nxt;

  logic                     sign;
  logic                     accept;
  logic signed [MAG_W-1:0]  in_ext;
  logic        [MAG_W-1:0]  mag_in;
  logic                     mul_done;
  logic        [AW-1:0]     prod;
  logic        [AW:0]       r_mag;
  logic                     sat_c;
  logic signed [OUT_W-1:0]  res_c;

  // Add the rounding offset (one extra bit absorbs the carry), then drop
  // the fractional bits.
  function automatic logic [AW:0] round_mag(input logic [AW-1:0] p);
    logic [AW:0] s;
    s = {1'b0, p} + HALF;
    return s >> FRAC_W;
  endfunction

  function automatic logic is_sat(input logic [AW:0] r, input logic neg);
    return LIM_W'(r) > sat_limit(OUT_W, neg);
  endfunction

  // Clipped magnitude, then sign applied; -0 collapses to +0 naturally.
  function automatic logic signed [OUT_W-1:0] saturate(input logic [AW:0] r,
                                                       input logic neg);
    logic [LIM_W-1:0] m;
    logic [OUT_W-1:0] mo;
    m  = is_sat(r, neg) ? sat_limit(OUT_W, neg) : LIM_W'(r);
    mo = m[OUT_W-1:0];
    return neg ? -$signed(mo) : $signed(mo);
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;

  // One extra bit so |most-negative| is exact.
  assign in_ext = $signed({in_data[IN_W-1], in_data});
  assign mag_in = in_data[IN_W-1] ? MAG_W'(-in_ext) : MAG_W'(in_ext);

  shift_add_mul #(
    .A_W (MAG_W),
    .B_W (SCALE_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .a     (mag_in),
    .b     (SCALE_W'(SCALE)),
    .done  (mul_done),
    .prod  (prod)
  );

  always_comb begin
    r_mag = round_mag(prod);
    sat_c = is_sat(r_mag, sign);
    res_c = saturate(r_mag, sign);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)  state_nxt = MUL;
      MUL:  if (mul_done)  state_nxt = RND;
      RND:                 state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) sign <= in_data[IN_W-1];
      // RND: product is final, publish rounded/clipped result
      if (state == RND) begin
        out_valid <= 1'b1;
        out_data  <= res_c;
        out_sat   <= sat_c;
      end
      // OUT: release on handshake; data stays as last result
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_to_scaled_int.sv
module tb_fixed_to_scaled_int;

  localparam int FRAC  = 8;
  localparam int SCALE = 1000;
  localparam int LAT   = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic        rdy_r, vld_r, sat_r;
  logic [31:0] dat_r;
  logic        rdy_t, vld_t, sat_t;
  logic [31:0] dat_t;
  logic        rdy_s, vld_s, sat_s;
  logic [9:0]  dat_s;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Default build: round half away, 32-bit output
  fixed_to_scaled_int dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .in_data(in_data),
    .out_valid(vld_r), .out_ready(out_ready), .out_data(dat_r), .out_sat(sat_r));

  // Truncating build
  fixed_to_scaled_int #(.ROUND_MODE(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_t), .in_data(in_data),
    .out_valid(vld_t), .out_ready(out_ready), .out_data(dat_t), .out_sat(sat_t));

  // Narrow-output build, exercises saturation
  fixed_to_scaled_int #(.OUT_W(10)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s), .out_sat(sat_s));

  // Reference: value*SCALE from plain integer arithmetic on the real value.
  function automatic longint model(input int d, input int mode, input int out_w,
                                   output bit sat);
    longint mag, p, r, lim;
    mag = (d < 0) ? -d : d;
    p   = mag * SCALE;
    r   = (mode == 1) ? (p + (64'sd1 <<< (FRAC - 1))) / (64'sd1 <<< FRAC)
                      : p / (64'sd1 <<< FRAC);
    lim = (d < 0) ? (64'sd1 <<< (out_w - 1)) : (64'sd1 <<< (out_w - 1)) - 1;
    sat = (r > lim);
    if (sat) r = lim;
    return (d < 0) ? -r : r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int d);
    longint e;
    bit     s;
    e = model(d, 1, 32, s);
    check("round_data", 64'(dat_r), 64'(e[31:0]));
    check("round_sat",  64'(sat_r), 64'(s));
    e = model(d, 0, 32, s);
    check("trunc_data", 64'(dat_t), 64'(e[31:0]));
    check("trunc_sat",  64'(sat_t), 64'(s));
    e = model(d, 1, 10, s);
    check("narrow_data", 64'(dat_s), 64'(e[9:0]));
    check("narrow_sat",  64'(sat_s), 64'(s));
  endtask

  // Waits (bounded) for out_valid after the accept edge and checks latency.
  task automatic wait_result(input int d);
    int k;
    k = 0;
    while (!vld_r && k < 4 * LAT) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k), 64'(LAT));
    check("valid_trunc",  64'(vld_t), 64'd1);
    check("valid_narrow", 64'(vld_s), 64'd1);
    check_outputs(d);
  endtask

  // One full transaction with out_ready high.
  task automatic run_word(input int d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 10'(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 64'(rdy_r), 64'd0);
    wait_result(d);
    @(posedge clk); #1;
    check("valid_dropped", 64'(vld_r), 64'd0);
    check("ready_back",    64'(rdy_r), 64'd1);
  endtask

  initial begin
    int dir[7];
    int d, d2;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready",  64'(rdy_r), 64'd1);
    check("rst_out_valid", 64'(vld_r), 64'd0);
    check("rst_out_data",  64'(dat_r), 64'd0);
    check("rst_out_sat",   64'(sat_r), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("ready_after_rst", 64'(rdy_r), 64'd1);

    // Directed values: typical, negative, most-negative, rounding edges, zero
    dir = '{181, -181, -512, 1, -1, 0, 64};
    foreach (dir[i]) run_word(dir[i]);

    // Randomized words
    for (int i = 0; i < 25; i++) begin
      d = int'($urandom_range(0, 1023)) - 512;
      run_word(d);
    end

    // Backpressure: hold out_ready low with a new word waiting at the input
    d  = int'($urandom_range(0, 1023)) - 512;
    d2 = 181;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 10'(d);
    @(posedge clk); #1;
    in_data = 10'(d2);
    wait_result(d);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_data = 10'($urandom_range(0, 1023));
      check("bp_valid",    64'(vld_r), 64'd1);
      check("bp_in_ready", 64'(rdy_r), 64'd0);
      check_outputs(d);
    end
    in_data   = 10'(d2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 64'(vld_r), 64'd0);
    check("bp_ready_rise", 64'(rdy_r), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_next", 64'(rdy_r), 64'd0);
    wait_result(d2);
    @(posedge clk); #1;
    check("bp_idle", 64'(rdy_r), 64'd1);

    // Asynchronous reset in MUL cycle 4 (out_data still holds 707)
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 10'd181;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(vld_r), 64'd0);
    check("arst_out_data",  64'(dat_r), 64'd0);
    check("arst_out_sat",   64'(sat_r), 64'd0);
    check("arst_in_ready",  64'(rdy_r), 64'd1);
    check("arst_narrow",    64'(dat_s), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("post_rst_ready", 64'(rdy_r), 64'd1);
    run_word(181);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time bound in case the bench itself stalls
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", compared);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fixed_to_scaled_int.md
Name: fixed_to_scaled_int

Overview:
Sequential converter from a signed two's-complement fixed-point word to a signed integer equal to value × SCALE, e.g. value×1000 for three-decimal display or logging. It uses an iterative shift-add multiplier, selectable rounding, saturation and valid/ready handshakes on both sides. It sits between fixed-point datapath outputs and the binary/decimal output stage of the conversion chain.

Parameters:
IN_W, 10, input width, two's complement
FRAC_W, 8, fractional bits of input (value = in_data / 2^FRAC_W); 0 ≤ FRAC_W < IN_W+SCALE_W
SCALE, 1000, positive integer multiplier constant
OUT_W, 32, output width, two's complement
ROUND_MODE, 1, 0 = truncate toward zero, 1 = round half away from zero
SCALE_W, $clog2(SCALE+1), localparam, multiplier bit count (10 for 1000)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input word present
in_ready  out  1  block idle, will accept
in_data  in  IN_W  fixed-point input
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  scaled signed integer
out_sat  out  1  result was clipped (qualified by out_valid)

Behaviour:
- Clocking and reset: one clock; rst asynchronous, active-high. On reset: state=IDLE, out_valid=0, out_data=0, out_sat=0, all internal accumulators 0. in_ready = (state==IDLE), so it reads 1 from reset onward. No input is captured while rst=1.
- FSM states: IDLE, MUL, RND, OUT.
- IDLE: on in_valid&&in_ready at edge T:
  - latch sign = in_data[IN_W-1]
  - latch mag = |in_data| in IN_W+1 bits, so the most-negative input is exact
  - clear acc (IN_W+1+SCALE_W bits) and bit counter
  - go to MUL.
- MUL: one multiplier bit per cycle, i = 0..SCALE_W-1. If SCALE[i]=1, acc += mag<<i. After bit SCALE_W-1 (edge T+SCALE_W), go to RND.
- RND, one cycle at edge T+SCALE_W+1:
  - r = (acc + (ROUND_MODE ? 2^(FRAC_W-1) : 0)) >> FRAC_W; when FRAC_W=0, no add.
  - Positive limit 2^(OUT_W-1)-1; negative limit 2^(OUT_W-1).
  - If r exceeds the limit for its sign: clip to the limit, out_sat=1. Otherwise out_sat=0.
  - out_data = sign ? -r : r. Zero magnitude always gives +0.
  - Set out_valid=1, go to OUT.
- Latency: out_valid is high from edge T+SCALE_W+1 (11 cycles at defaults). Latency is independent of data.
- OUT:
  - out_data and out_sat hold stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 at that edge, go to IDLE. in_ready rises the following cycle.
  - No overlap: one word in flight. Throughput is 1 per SCALE_W+3 cycles with out_ready tied high.
- in_data changes while busy are ignored. in_valid with in_ready=0 is not an error; the word is simply not taken.
- rst mid-operation (any state) aborts the word. Outputs return to reset values immediately. The in-flight word is lost, with no partial output.
- Arithmetic: acc width IN_W+1+SCALE_W, so there is no internal overflow. Saturation applies only at OUT_W.
- Widths of 1 for FRAC_W are legal. SCALE=1 is legal; SCALE_W is then 1.

Decomposition:
- Shared package fxp_conv_pkg holds:
  - the state enum (IDLE/MUL/RND/OUT)
  - rounding-mode constants RND_TRUNC=0 and RND_HALF_AWAY=1
  - a function for the saturation limits given OUT_W
- One natural sub-module: shift_add_mul, the iterative unsigned multiplier with start/done, parametrised on operand widths. The top holds the FSM, sign handling, rounding and saturation.

Test Plan:
- Defaults, in_data=10'b0010110101 (181 = 0.70703125), out_ready=1 → after 11 cycles out_valid=1, out_data=707 (0x000002C3), out_sat=0.
- in_data=-181 (10'b1101001011) → out_data=-707 (0xFFFFFD3D). in_data=10'b1000000000 (-2.0) → out_data=-2000 (0xFFFFF830), out_sat=0.
- Rounding with in_data=1 (3.906):
  - ROUND_MODE=1 → 4.
  - ROUND_MODE=0 → 3.
  - in_data=-1 → -4 and -3 respectively.
  - in_data=0 → 0 in both modes.
- OUT_W=10 saturation:
  - in_data=181 → 511, out_sat=1.
  - in_data=-512 → -512 (0x200), out_sat=1.
  - in_data=64 (250) → 250, out_sat=0.
- Backpressure: out_ready low for 5 cycles after out_valid, with in_valid held high and new data → out_data/out_sat stable and in_ready=0 throughout. After the out_ready handshake, in_ready=1 next cycle and the new word is accepted.
- Reset: assert rst asynchronously in MUL cycle 4 → out_valid=0, out_data=0 without a clock edge. After release, in_ready=1. A fresh 181 input then yields 707 with exact 11-cycle latency.
